// File: rtl/pma_tx_ser_ctrl_if.sv
// PCS/management/PISO signal bundle for the PMA transmit serializer sequencer.
// The master side is the management/PCS/PISO environment; the slave side is the sequencer.
interface pma_tx_ser_ctrl_if #(
    parameter int unsigned CG_W = 10
);
    logic            tx_en;
    logic [CG_W-1:0] tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            ewrap_req;
    logic            piso_load;
    logic [CG_W-1:0] piso_data;
    logic            EWRAP;
    logic            running;
    logic [7:0]      underrun_cnt;

    modport master (
        output tx_en, tx_data, tx_valid, ewrap_req,
        input  tx_ready, piso_load, piso_data, EWRAP, running, underrun_cnt
    );

    modport slave (
        input  tx_en, tx_data, tx_valid, ewrap_req,
        output tx_ready, piso_load, piso_data, EWRAP, running, underrun_cnt
    );
endinterface

// File: rtl/pma_tx_ser_ctrl.sv
// Transmit-side sequencer for the PMA serializer: paces PISO loads, runs the
// startup idle sequence, fills PCS underruns with idles and aligns EWRAP to word boundaries.
module pma_tx_ser_ctrl #(
    parameter int unsigned     CG_W       = 10,
    parameter logic [CG_W-1:0] IDLE_CG    = CG_W'(10'h0FA),
    parameter int unsigned     STARTUP_CG = 4
) (
    input logic               clk,
    input logic               reset_n,
    pma_tx_ser_ctrl_if.slave  bus
);

    localparam int unsigned     CntW        = (CG_W > 1) ? $clog2(CG_W) : 1;
    localparam logic [CntW-1:0] LastBit     = CntW'(CG_W - 1);
    localparam logic [7:0]      LastStartup = 8'(STARTUP_CG - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e          state;
    logic [CntW-1:0] bit_cnt;
    logic [7:0]      cg_cnt;
    logic [7:0]      underrun_cnt;
    logic            ewrap;
    logic            load;
    logic            in_run;

    assign load   = (bit_cnt == LastBit);
    assign in_run = (state == StRun);

    // Data is only taken from the PCS in RUN with management enable; otherwise idles fill the slot.
    assign bus.piso_load    = load;
    assign bus.tx_ready     = load & in_run & bus.tx_en;
    assign bus.piso_data    = (in_run && bus.tx_en && bus.tx_valid) ? bus.tx_data : IDLE_CG;
    assign bus.running      = in_run;
    assign bus.EWRAP        = ewrap;
    assign bus.underrun_cnt = underrun_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt      <= '0;
            state        <= StInit;
            cg_cnt       <= '0;
            underrun_cnt <= '0;
            ewrap        <= 1'b0;
        end else begin
            bit_cnt <= load ? '0 : bit_cnt + CntW'(1);
            // All sequencing decisions are taken on word boundaries only.
            if (load) begin
                ewrap <= bus.ewrap_req;
                unique case (state)
                    StInit: begin
                        if (bus.tx_en) begin
                            if (cg_cnt == LastStartup) begin
                                state  <= StRun;
                                cg_cnt <= '0;
                            end else begin
                                cg_cnt <= cg_cnt + 8'd1;
                            end
                        end
                    end
                    StRun: begin
                        if (!bus.tx_en) begin
                            state  <= StInit;
                            cg_cnt <= '0;
                        end else if (!bus.tx_valid && underrun_cnt != 8'hFF) begin
                            underrun_cnt <= underrun_cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pma_tx_ser_ctrl.sv
// Bench for pma_tx_ser_ctrl: cycle-indexed behavioural model checked every cycle,
// plus directed literal expectations at the key boundaries.
module tb_pma_tx_ser_ctrl;

    localparam int unsigned CG_W    = 10;
    localparam logic [9:0]  IDLE    = 10'h0FA;
    localparam int          STARTUP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pma_tx_ser_ctrl_if #(.CG_W(CG_W)) bus ();

    pma_tx_ser_ctrl #(
        .CG_W       (CG_W),
        .IDLE_CG    (IDLE),
        .STARTUP_CG (STARTUP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: cycle index since reset release, mode, idles counted toward startup, underruns.
    int m_cyc     = 0;
    int m_startup = 0;
    int m_under   = 0;
    bit m_run     = 1'b0;
    bit m_ewrap   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    always @(negedge clk) begin
        bit         ld;
        logic [9:0] ep;
        if (!reset_n) begin
            m_cyc     = 0;
            m_run     = 1'b0;
            m_startup = 0;
            m_under   = 0;
            m_ewrap   = 1'b0;
            ld        = 1'b0;
        end else begin
            ld = ((m_cyc % CG_W) == CG_W - 1);
        end
        ep = (reset_n && m_run && bus.tx_en && bus.tx_valid) ? bus.tx_data : IDLE;
        check("cyc_piso_load", 32'(bus.piso_load), 32'(ld));
        check("cyc_tx_ready", 32'(bus.tx_ready), 32'(ld && m_run && bus.tx_en));
        check("cyc_piso_data", 32'(bus.piso_data), 32'(ep));
        check("cyc_running", 32'(bus.running), 32'(m_run));
        check("cyc_ewrap", 32'(bus.EWRAP), 32'(m_ewrap));
        check("cyc_underrun", 32'(bus.underrun_cnt), 32'(m_under));
        if (reset_n) begin
            if (ld) begin
                m_ewrap = bus.ewrap_req;
                if (m_run) begin
                    if (!bus.tx_en) begin
                        m_run     = 1'b0;
                        m_startup = 0;
                    end else if (!bus.tx_valid) begin
                        m_under = (m_under < 255) ? m_under + 1 : 255;
                    end
                end else if (bus.tx_en) begin
                    m_startup++;
                    if (m_startup == STARTUP) begin
                        m_run     = 1'b1;
                        m_startup = 0;
                    end
                end
            end
            m_cyc++;
        end
    end

    task automatic wait_to(input int c);
        int g = 0;
        while (m_cyc < c && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (m_cyc != c) bound_fail($sformatf("wait_to_%0d", c));
    endtask

    task automatic wait_bit(input int k);
        int g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while ((m_cyc % CG_W) != k && g < 2 * CG_W);
        if ((m_cyc % CG_W) != k) bound_fail($sformatf("wait_bit_%0d", k));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_piso_load"}, 32'(bus.piso_load), 32'd0);
        check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd0);
        check({tag, "_running"}, 32'(bus.running), 32'd0);
        check({tag, "_piso_data"}, 32'(bus.piso_data), 32'h0FA);
        check({tag, "_underrun"}, 32'(bus.underrun_cnt), 32'd0);
        check({tag, "_ewrap"}, 32'(bus.EWRAP), 32'd0);
    endtask

    initial begin
        bus.tx_en     = 1'b1;
        bus.tx_valid  = 1'b1;
        bus.tx_data   = 10'h155;
        bus.ewrap_req = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");

        // Startup: idles at 9,19,29,39, RUN from 40, first data at 49.
        reset_n = 1'b1;
        wait_to(9);
        check("st_load9", 32'(bus.piso_load), 32'd1);
        check("st_data9", 32'(bus.piso_data), 32'h0FA);
        check("st_ready9", 32'(bus.tx_ready), 32'd0);
        wait_to(39);
        check("st_load39", 32'(bus.piso_load), 32'd1);
        check("st_run39", 32'(bus.running), 32'd0);
        wait_to(40);
        check("st_run40", 32'(bus.running), 32'd1);
        wait_to(49);
        check("st_ready49", 32'(bus.tx_ready), 32'd1);
        check("st_data49", 32'(bus.piso_data), 32'h155);

        // Three underruns at 59, 69, 79.
        wait_to(50);
        bus.tx_valid = 1'b0;
        wait_to(59);
        check("ur_ready59", 32'(bus.tx_ready), 32'd1);
        check("ur_data59", 32'(bus.piso_data), 32'h0FA);
        wait_to(80);
        check("ur_cnt3", 32'(bus.underrun_cnt), 32'd3);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 10'h2A3;

        // EWRAP: mid-word pulse ignored, held request taken at next boundary.
        wait_bit(3);
        bus.ewrap_req = 1'b1;
        wait_bit(6);
        bus.ewrap_req = 1'b0;
        wait_bit(0);
        check("ew_pulse", 32'(bus.EWRAP), 32'd0);
        wait_bit(5);
        bus.ewrap_req = 1'b1;
        wait_bit(9);
        check("ew_before", 32'(bus.EWRAP), 32'd0);
        wait_bit(0);
        check("ew_after", 32'(bus.EWRAP), 32'd1);

        // tx_en drop mid-word, then restart with a fresh startup sequence.
        bus.tx_data = 10'h3C7;
        wait_bit(4);
        bus.tx_en = 1'b0;
        wait_bit(9);
        check("en_load", 32'(bus.piso_load), 32'd1);
        check("en_ready", 32'(bus.tx_ready), 32'd0);
        check("en_data", 32'(bus.piso_data), 32'h0FA);
        check("en_run_pre", 32'(bus.running), 32'd1);
        wait_bit(0);
        check("en_run_post", 32'(bus.running), 32'd0);
        wait_bit(9);
        wait_bit(9);
        wait_bit(2);
        bus.tx_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_bit(9);
            check($sformatf("en_restart_ready%0d", i), 32'(bus.tx_ready), 32'(i == 4));
        end
        check("en_restart_data", 32'(bus.piso_data), 32'h3C7);

        // Saturation after 300 more underruns.
        bus.tx_valid = 1'b0;
        repeat (300) wait_bit(0);
        check("sat_255", 32'(bus.underrun_cnt), 32'd255);
        repeat (5) wait_bit(0);
        check("sat_hold", 32'(bus.underrun_cnt), 32'd255);

        // Reset mid-word takes effect immediately.
        wait_bit(5);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        bus.tx_valid = 1'b1;
        wait_to(8);
        check("rst_noload8", 32'(bus.piso_load), 32'd0);
        wait_to(9);
        check("rst_load9", 32'(bus.piso_load), 32'd1);
        check("rst_data9", 32'(bus.piso_data), 32'h0FA);
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
